sop_sweep_checker: RTL and testbench

SOP_SWEEP_CHECKER -- requirements
Module: sop_sweep_checker

---
 rtl/sop_sweep_checker.sv | 156 +++++++++++++++
 tb/tb_sop_sweep_checker.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sop_sweep_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sop_sweep_checker: sweeps x,y,z over 000..111 and checks cout against    |
// | (x & ~y) | (y & z). Optional first-failure capture: SOP_CHK_FIRST_FAIL_EN |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sop_sweep_checker #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       x,
  output logic       y,
  output logic       z,
  input  logic       cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
`ifdef SOP_CHK_FIRST_FAIL_EN
  output logic       fail_valid,
  output logic [2:0] fail_vec,
`endif
  output logic [3:0] err_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // WAIT exits when the counter reaches zero, so it is loaded with SETTLE-1.
  localparam int         SETTLE_LD   = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [3:0] C_SETTLE_LD = 4'(SETTLE_LD);

  state_t     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [2:0] xyz_q, xyz_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] err_q, err_d;
  logic       exp_bit;
  logic       mismatch;

`ifdef SOP_CHK_FIRST_FAIL_EN
  logic       fv_q, fv_d;
  logic [2:0] fvec_q, fvec_d;
`endif

  assign exp_bit  = (vec_q[2] & ~vec_q[1]) | (vec_q[1] & vec_q[0]);
  assign mismatch = (cout != exp_bit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= 3'd0;
      xyz_q   <= 3'd0;
      cnt_q   <= 4'd0;
      err_q   <= 4'd0;
`ifdef SOP_CHK_FIRST_FAIL_EN
      fv_q    <= 1'b0;
      fvec_q  <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      xyz_q   <= xyz_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef SOP_CHK_FIRST_FAIL_EN
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
`endif
    end
  end

  // The stimulus register is loaded on entry to DRIVE so it stays stable
  // for the whole DRIVE/WAIT/SAMPLE window of a vector.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    xyz_d   = xyz_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef SOP_CHK_FIRST_FAIL_EN
    fv_d    = fv_q;
    fvec_d  = fvec_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        xyz_d = 3'd0;
        if (start) begin
          state_d = S_DRIVE;
          vec_d   = 3'd0;
          err_d   = 4'd0;
`ifdef SOP_CHK_FIRST_FAIL_EN
          fv_d    = 1'b0;
          fvec_d  = 3'd0;
`endif
        end
      end
      S_DRIVE: begin
        if (SETTLE > 0) begin
          state_d = S_WAIT;
          cnt_d   = C_SETTLE_LD;
        end else begin
          state_d = S_SAMPLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + 4'd1;
`ifdef SOP_CHK_FIRST_FAIL_EN
          if (!fv_q) begin
            fv_d   = 1'b1;
            fvec_d = vec_q;
          end
`endif
        end
        if (vec_q == 3'd7) begin
          state_d = S_DONE;
          xyz_d   = 3'd0;
        end else begin
          state_d = S_DRIVE;
          vec_d   = vec_q + 3'd1;
          xyz_d   = vec_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign x         = xyz_q[2];
  assign y         = xyz_q[1];
  assign z         = xyz_q[0];
  assign busy      = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_SAMPLE);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_q == 4'd0);
  assign err_count = err_q;

`ifdef SOP_CHK_FIRST_FAIL_EN
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sop_sweep_checker.sv
`default_nettype none
// Bench for sop_sweep_checker: two instances (SETTLE=1 and SETTLE=0) driven by
// a response model with selectable fault patterns, checked against counted expectations.
module tb_sop_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start1, start0;
  logic       x1, y1, z1, x0, y0, z0;
  logic       cout1, cout0;
  logic       busy1, done1, pass1, busy0, done0, pass0;
  logic [3:0] err1, err0;
`ifdef SOP_CHK_FIRST_FAIL_EN
  logic       fv1, fv0;
  logic [2:0] fvec1, fvec0;
`endif

  int         mode1, mode0;
  logic [7:0] mask1, mask0;
  int         sel;
  int         n_assert;
  int         n_fail;

  sop_sweep_checker #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .x(x1), .y(y1), .z(z1), .cout(cout1),
    .busy(busy1), .done(done1), .pass(pass1),
`ifdef SOP_CHK_FIRST_FAIL_EN
    .fail_valid(fv1), .fail_vec(fvec1),
`endif
    .err_count(err1)
  );

  sop_sweep_checker #(.SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .x(x0), .y(y0), .z(z0), .cout(cout0),
    .busy(busy0), .done(done0), .pass(pass0),
`ifdef SOP_CHK_FIRST_FAIL_EN
    .fail_valid(fv0), .fail_vec(fvec0),
`endif
    .err_count(err0)
  );

  // Golden value straight from the sum-of-products formula.
  function automatic logic golden(input logic [2:0] v);
    return (v[2] & ~v[1]) | (v[1] & v[0]);
  endfunction

  // Device-under-test stand-in: 0 correct, 1 stuck-0, 2 stuck-1, 3 inverted,
  // 4 correct with per-vector flips given by mask.
  function automatic logic resp(input int mode, input logic [7:0] mask, input logic [2:0] v);
    case (mode)
      0:       return golden(v);
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return ~golden(v);
      default: return golden(v) ^ mask[v];
    endcase
  endfunction

  assign cout1 = resp(mode1, mask1, {x1, y1, z1});
  assign cout0 = resp(mode0, mask0, {x0, y0, z0});

  logic       cur_busy, cur_done, cur_pass;
  logic [2:0] cur_xyz;
  logic [3:0] cur_err;
  logic       cur_fv;
  logic [2:0] cur_fvec;
  always_comb begin
    cur_busy = (sel == 1) ? busy1 : busy0;
    cur_done = (sel == 1) ? done1 : done0;
    cur_pass = (sel == 1) ? pass1 : pass0;
    cur_xyz  = (sel == 1) ? {x1, y1, z1} : {x0, y0, z0};
    cur_err  = (sel == 1) ? err1 : err0;
`ifdef SOP_CHK_FIRST_FAIL_EN
    cur_fv   = (sel == 1) ? fv1 : fv0;
    cur_fvec = (sel == 1) ? fvec1 : fvec0;
`else
    cur_fv   = 1'b0;
    cur_fvec = 3'd0;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One full sweep on the selected instance; checks timing, stimulus stability and results.
  task automatic run_sweep(input int s, input int settle, input int mode,
                           input logic [7:0] mask, input bit inject);
    int   per;
    int   k;
    int   exp_err;
    int   first;
    bit   found;
    logic c;
    per = settle + 2;
    exp_err = 0; first = 0; found = 1'b0;
    for (int v = 0; v < 8; v++) begin
      c = resp(mode, mask, 3'(v));
      if (c != golden(3'(v))) begin
        exp_err++;
        if (!found) begin first = v; found = 1'b1; end
      end
    end
    if (s == 1) begin mode1 = mode; mask1 = mask; end
    else        begin mode0 = mode; mask0 = mask; end
    sel = s;
    @(negedge clk);
    if (s == 1) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start0 = 1'b0;
    chk("err_cleared_on_start", cur_err, 0);
    chk("fail_cleared_on_start", cur_fv, 0);
    k = 0;
    while (k < 8 * per) begin
      chk("busy_in_sweep", cur_busy, 1);
      chk("done_low_in_sweep", cur_done, 0);
      chk("xyz_schedule", cur_xyz, k / per);
      if (inject && (k == 5)) begin
        if (s == 1) start1 = 1'b1; else start0 = 1'b1;
      end
      @(posedge clk); #1;
      start1 = 1'b0; start0 = 1'b0;
      k++;
    end
    chk("done_at_end", cur_done, 1);
    chk("busy_at_end", cur_busy, 0);
    chk("xyz_at_end", cur_xyz, 0);
    chk("err_count", cur_err, exp_err);
    chk("pass", cur_pass, (exp_err == 0) ? 1 : 0);
`ifdef SOP_CHK_FIRST_FAIL_EN
    chk("fail_valid", cur_fv, found ? 1 : 0);
    chk("fail_vec", cur_fvec, first);
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("done_held", cur_done, 1);
    chk("err_held", cur_err, exp_err);
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    rst = 1'b1; start1 = 1'b0; start0 = 1'b0;
    mode1 = 0; mode0 = 0; mask1 = 8'h00; mask0 = 8'h00; sel = 1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy1", busy1, 0);   chk("rst_done1", done1, 0);
    chk("rst_pass1", pass1, 0);   chk("rst_err1", err1, 0);
    chk("rst_xyz1", {x1, y1, z1}, 0);
    chk("rst_busy0", busy0, 0);   chk("rst_done0", done0, 0);
    chk("rst_err0", err0, 0);
`ifdef SOP_CHK_FIRST_FAIL_EN
    chk("rst_fv1", fv1, 0);       chk("rst_fvec1", fvec1, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", busy1, 0);

    run_sweep(1, 1, 0, 8'h00, 1'b1);   // correct model, stray start mid-sweep
    run_sweep(1, 1, 1, 8'h00, 1'b0);   // stuck-0
    run_sweep(1, 1, 3, 8'h00, 1'b0);   // inverted
    run_sweep(1, 1, 2, 8'h00, 1'b0);   // stuck-1
    run_sweep(1, 1, 0, 8'h00, 1'b0);   // restart from a failing DONE
    run_sweep(0, 0, 0, 8'h00, 1'b1);   // no settle cycles
    run_sweep(0, 0, 1, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) run_sweep(0, 0, 4, 8'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) run_sweep(1, 1, 4, 8'($urandom), 1'b0);

    // Reset while vector 4 is in WAIT, with start asserted in the same cycle.
    mode1 = 1; sel = 1;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy1, 1);
    chk("pre_rst_xyz", {x1, y1, z1}, 4);
    chk("pre_rst_err", err1, 1);
    rst = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start1 = 1'b0;
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_xyz", {x1, y1, z1}, 0);
    chk("mid_rst_err", err1, 0);
    chk("mid_rst_done", done1, 0);
    @(posedge clk); #1;
    chk("rst_beats_start", busy1, 0);

    run_sweep(1, 1, 0, 8'h00, 1'b0);   // recovers after reset

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
